// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus master initiator: polarity constants,
// default widths, FSM state encoding and the timeout-counter width helper.
package bus_master_if_pkg;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2
  } bus_state_e;

  // Counter is wide enough for the limit, but never narrower than 8 or wider than 16 bits.
  function automatic int cnt_width(input int lim);
    int w;
    w = $clog2(lim + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// Master-side bus signal group: request/grant, address strobe, ready and data.
interface bus_master_if_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );

endinterface

// File: rtl/bus_master_if_timeout_cnt.sv
// ACCESS-state watchdog: counts ready-less access cycles and flags the cycle
// on which the limit is reached. Only instantiated when BUS_TIMEOUT_EN is defined.
module bus_master_if_timeout_cnt
  import bus_master_if_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CNT_W = cnt_width(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the LIMIT-th ready-less cycle so the abort lands on the following edge.
  assign hit = inc && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_master_if.sv
// Master-side initiator: turns a single-word core access into request/grant/strobe/ready.
// Optional ACCESS watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_rw,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  bus_master_if_if.master   bus
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  bus_state_e        state;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rw;
  logic [DATA_W-1:0] lat_wr_data;

`ifdef BUS_TIMEOUT_EN
  logic to_clr;
  logic to_inc;
  logic to_hit;

  assign to_clr = (state == REQ) && (bus.bus_grnt_ == ENABLE_);
  assign to_inc = (state == ACCESS) && (bus.bus_rdy_ == DISABLE_);

  bus_master_if_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .inc (to_inc),
    .hit (to_hit)
  );
`else
  assign core_err = 1'b0;
`endif

  // Request capture: later core-side changes cannot disturb an access in flight.
  always_ff @(posedge clk) begin
    if (state == IDLE && core_req) begin
      lat_addr    <= core_addr;
      lat_rw      <= core_rw;
      lat_wr_data <= core_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bus.bus_req_    <= DISABLE_;
      bus.bus_as_     <= DISABLE_;
      bus.bus_rw      <= READ;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
      core_rd_data    <= '0;
      core_busy       <= 1'b0;
      core_done       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      core_err        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          core_done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          core_err  <= 1'b0;
`endif
          if (core_req) begin
            bus.bus_req_ <= ENABLE_;
            core_busy    <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_grnt_ == ENABLE_) begin
            bus.bus_as_     <= ENABLE_;
            bus.bus_addr    <= lat_addr;
            bus.bus_rw      <= lat_rw;
            bus.bus_wr_data <= lat_wr_data;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          // Ready takes priority over a coincident timeout.
          if (bus.bus_rdy_ == ENABLE_) begin
            bus.bus_req_    <= DISABLE_;
            bus.bus_as_     <= DISABLE_;
            bus.bus_addr    <= '0;
            bus.bus_rw      <= READ;
            bus.bus_wr_data <= '0;
            core_done       <= 1'b1;
            core_busy       <= 1'b0;
            if (lat_rw == READ) core_rd_data <= bus.bus_rd_data;
            state           <= IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (to_hit) begin
            bus.bus_req_    <= DISABLE_;
            bus.bus_as_     <= DISABLE_;
            bus.bus_addr    <= '0;
            bus.bus_rw      <= READ;
            bus.bus_wr_data <= '0;
            core_done       <= 1'b1;
            core_err        <= 1'b1;
            core_busy       <= 1'b0;
            core_rd_data    <= '0;
            state           <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Master-side initiator for the shared 4-master/8-slave bus.
- Converts a single-word core-side access request into the bus protocol: request, wait for grant, address strobe, wait for ready, release.
- One instance sits between each bus master (CPU IF/MEM stage, DMA) and its m*_ port group on the bus.
- It is the requesting end of the arbiter and slave-ready handshake.

Parameters:
- ADDR_W, 30, word address width (matches WordAddrBus).
- DATA_W, 32, data width (matches WordDataBus).
- TIMEOUT_CYC, 255, ACCESS-state cycle limit; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- core_req  in  1  access request, active-high; sampled in IDLE only.
- core_addr  in  ADDR_W  word address.
- core_rw  in  1  1=read, 0=write.
- core_wr_data  in  DATA_W  write data.
- core_rd_data  out  DATA_W  read data, registered; valid while core_done=1 and held until the next read completes.
- core_busy  out  1  registered; high from the cycle after core_req is accepted until the done cycle.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  error qualifier for core_done.
- bus_req_  out  1  bus request, active-low.
- bus_grnt_  in  1  grant from arbiter, active-low.
- bus_addr  out  ADDR_W  address to master mux.
- bus_as_  out  1  address strobe, active-low.
- bus_rw  out  1  1=read, 0=write.
- bus_wr_data  out  DATA_W  write data to master mux.
- bus_rd_data  in  DATA_W  read data from slave mux.
- bus_rdy_  in  1  slave ready, active-low.

Behaviour:
- All outputs are registered.
- Reset values: bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, core_rd_data=0, core_busy=0, core_done=0, core_err=0, state=IDLE.
- Reset mid-access: all outputs return to reset values immediately (asynchronous); the access is dropped with no done pulse.
- States: IDLE, REQ, ACCESS.
- IDLE:
  - Request held high, bus_as_ high.
  - If core_req=1: latch core_addr/core_rw/core_wr_data; next cycle bus_req_=0, core_busy=1, go REQ.
- REQ:
  - bus_req_ held low.
  - On sampling bus_grnt_=0: next cycle bus_as_=0 and bus_addr/bus_rw/bus_wr_data are driven from the latches; go ACCESS.
  - Waiting for grant is unbounded.
- ACCESS:
  - bus_req_ and bus_as_ held low; bus_grnt_ is ignored.
  - On sampling bus_rdy_=0, the next cycle:
    - bus_req_=1, bus_as_=1;
    - bus_addr and bus_wr_data return to 0, bus_rw to 1;
    - core_done=1, core_busy=0;
    - if read, core_rd_data=bus_rd_data; if write, core_rd_data is unchanged;
    - go IDLE.
- Latency with immediate grant and zero-wait slave: core_req accepted at edge N; done at edge N+3.
- Back-to-back: core_req is ignored during the done cycle (the state is IDLE, but core_req is sampled only on the following edge). This gives a minimum one idle bus_req_=1 cycle between accesses, which lets the arbiter rotate.
- core_addr, core_rw and core_wr_data changes after acceptance have no effect.
- core_req dropping after acceptance does not cancel the access.
- core_err=0 at all times unless the feature below is enabled.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined:
  - An 8..16-bit counter (sized to TIMEOUT_CYC) clears on entry to ACCESS and increments each ACCESS cycle with bus_rdy_=1.
  - When the count reaches TIMEOUT_CYC without rdy_, the access is aborted the next cycle: bus_req_=1, bus_as_=1, core_done=1, core_err=1, core_rd_data=0, go IDLE.
  - If rdy_ and the limit coincide, rdy_ wins: normal completion, core_err=0.
- Without the macro: no counter is built; core_err is tied 0; ACCESS waits indefinitely.

Decomposition:
- Shared bus_pkg / define header holds:
  - READ=1 / WRITE=0;
  - ENABLE_=0 / DISABLE_=1;
  - ADDR_W/DATA_W defaults;
  - the 2-bit state encoding (IDLE=0, REQ=1, ACCESS=2).
- One natural sub-module: bus_timeout_cnt (counter + limit compare), instantiated only under BUS_TIMEOUT_EN.

Test Plan:
1. Read, immediate grant, zero-wait: core_req=1, addr=0x0000_0100, rw=1; grnt_ low next cycle; rdy_=0 with rd_data=0xDEADBEEF. Required: bus_as_ low exactly 1 cycle; core_done at edge N+3; core_rd_data=0xDEADBEEF; core_err=0.
2. Write with 3 wait states: addr=0x3FFF_FFFF, wr_data=0x12345678, rw=0; rdy_ low on the 4th ACCESS cycle. Required: bus_as_ low 4 cycles; bus_wr_data=0x12345678 throughout ACCESS; core_rd_data unchanged; core_done 1 cycle.
3. Delayed grant: grnt_ held high 10 cycles. Required: bus_req_ low all 10 cycles; bus_as_ high until the cycle after grant; core_busy=1 throughout.
4. Back-to-back: core_req held high across two accesses. Required: bus_req_ high for at least 1 cycle between them; second access uses the addr latched at its own acceptance.
5. Async reset during ACCESS: rst low mid-cycle. Required: bus_req_=1, bus_as_=1, core_busy=0 immediately; no core_done pulse; a new access after release completes normally.
6. BUS_TIMEOUT_EN, TIMEOUT_CYC=4, rdy_ never asserted. Required: abort after 4 ACCESS cycles; core_done=1, core_err=1, core_rd_data=0. Repeat with rdy_ on the limit cycle: core_err=0.
